// File: rtl/key_packet_receiver.sv
// Key packet receiver: accepts a typed header word followed by sixteen 16-bit payload
// words, assembles them into a 256-bit key and holds it until the consumer acknowledges.
module key_packet_receiver #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [3:0]  KEY_TYPE       = 4'h1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         rx_valid,
   input  logic [15:0]  rx_data,
   input  logic         key_ack,
   output logic [15:0]  incoming_packet_header,
   output logic [255:0] key_out,
   output logic         key_valid,
   output logic [4:0]   word_count,
   output logic         rx_error,
   output logic         dropped
);

   // Wide enough to hold TIMEOUT_CYCLES itself; the counter is cleared before it could wrap.
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StPayload, StHold} state_e;

   state_e         state_q, state_d;
   logic [255:0]   sr_q, sr_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [TmoW-1:0] tmo_inc;
   logic [15:0]    hdr_q, hdr_d;
   logic [255:0]   key_q, key_d;
   logic           kv_q, kv_d;
   logic [4:0]     wc_q, wc_d;
   logic           err_q, err_d;
   logic           drop_q, drop_d;

   assign tmo_inc = tmo_q + TmoW'(1);

   // Next-state and datapath decode for the three-state receive FSM.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      tmo_d   = tmo_q;
      hdr_d   = hdr_q;
      key_d   = key_q;
      kv_d    = kv_q;
      wc_d    = wc_q;
      err_d   = 1'b0;
      drop_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rx_valid && (rx_data[15:12] == KEY_TYPE)) begin
               hdr_d   = rx_data;
               wc_d    = 5'd0;
               tmo_d   = '0;
               sr_d    = '0;
               state_d = StPayload;
            end
         end
         StPayload: begin
            if (rx_valid) begin
               // Header-typed words are plain data here; no resynchronisation.
               sr_d  = {sr_q[239:0], rx_data};
               wc_d  = wc_q + 5'd1;
               tmo_d = '0;
               if (wc_q == 5'd15) begin
                  key_d   = {sr_q[239:0], rx_data};
                  kv_d    = 1'b1;
                  state_d = StHold;
               end
            end else if (tmo_inc == TmoW'(TIMEOUT_CYCLES)) begin
               // Abandon the packet; key and header registers keep their old contents.
               err_d   = 1'b1;
               wc_d    = 5'd0;
               tmo_d   = '0;
               state_d = StIdle;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         StHold: begin
            // Words arriving while a key is pending are lost, even alongside the ack.
            if (rx_valid) begin
               drop_d = 1'b1;
            end
            if (key_ack) begin
               kv_d    = 1'b0;
               wc_d    = 5'd0;
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers with asynchronous active-low clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         sr_q    <= '0;
         tmo_q   <= '0;
         hdr_q   <= '0;
         key_q   <= '0;
         kv_q    <= 1'b0;
         wc_q    <= 5'd0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         tmo_q   <= tmo_d;
         hdr_q   <= hdr_d;
         key_q   <= key_d;
         kv_q    <= kv_d;
         wc_q    <= wc_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   end

   assign incoming_packet_header = hdr_q;
   assign key_out                = key_q;
   assign key_valid              = kv_q;
   assign word_count             = wc_q;
   assign rx_error               = err_q;
   assign dropped                = drop_q;

endmodule

// File: tb/tb_key_packet_receiver.sv
// Self-checking bench for key_packet_receiver: table-driven packets plus hand sequences for
// timeout, HOLD drop/ack interaction and mid-packet reset; completed keys go through a queue.
module tb_key_packet_receiver;

   localparam int unsigned TMO = 32;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         rx_valid;
   logic [15:0]  rx_data;
   logic         key_ack;
   logic [15:0]  incoming_packet_header;
   logic [255:0] key_out;
   logic         key_valid;
   logic [4:0]   word_count;
   logic         rx_error;
   logic         dropped;

   key_packet_receiver #(
      .TIMEOUT_CYCLES(TMO),
      .KEY_TYPE      (4'h1)
   ) dut (
      .clock                 (clock),
      .reset_n               (reset_n),
      .rx_valid              (rx_valid),
      .rx_data               (rx_data),
      .key_ack               (key_ack),
      .incoming_packet_header(incoming_packet_header),
      .key_out               (key_out),
      .key_valid             (key_valid),
      .word_count            (word_count),
      .rx_error              (rx_error),
      .dropped               (dropped)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] hdr;
      logic [15:0] base;
      logic        incr;
      int          gap;
      logic        accept;
   } vec_t;

   typedef struct packed {
      logic [15:0]  hdr;
      logic [255:0] key;
   } exp_t;

   exp_t         sb[$];
   int           errors = 0;
   int           checks = 0;
   int           pushes = 0;
   int           pops   = 0;
   int           err_cnt = 0;
   logic         kv_prev = 1'b0;
   logic [15:0]  exp_hdr  = 16'h0;
   logic [255:0] last_key = '0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: each rising key_valid must match the oldest expected packet.
   always @(negedge clock) begin
      if (key_valid && !kv_prev) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: key_valid rose with key %0h but none expected", key_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_key", key_out, e.key);
            check("sb_hdr", {240'h0, incoming_packet_header}, {240'h0, e.hdr});
            pops++;
         end
      end
      if (rx_error) err_cnt++;
      kv_prev <= key_valid;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [15:0] w);
      rx_valid = 1'b1;
      rx_data  = w;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_packet(input logic [15:0] hdr, input logic [15:0] base, input logic incr,
                              input int gap, input logic accept);
      logic [255:0] exp_key;
      logic [15:0]  w;
      exp_key = '0;
      if (accept) exp_hdr = hdr;
      send(hdr);
      check("hdr_latch", {240'h0, incoming_packet_header}, {240'h0, exp_hdr});
      check("wc_after_hdr", {251'h0, word_count}, 256'd0);
      for (int i = 0; i < 16; i++) begin
         repeat (gap) tick();
         w = incr ? base + 16'(i) : base;
         if (accept) begin
            exp_key = {exp_key[239:0], w};
            if (i == 15) begin
               sb.push_back('{hdr: hdr, key: exp_key});
               pushes++;
            end
         end
         send(w);
         if (accept && i == 14) check("wc_15", {251'h0, word_count}, 256'd15);
      end
      if (accept) begin
         last_key = exp_key;
         check("kv_after_16", {255'h0, key_valid}, 256'd1);
         check("wc_16", {251'h0, word_count}, 256'd16);
      end else begin
         check("kv_reject", {255'h0, key_valid}, 256'd0);
         check("wc_reject", {251'h0, word_count}, 256'd0);
         check("hdr_reject", {240'h0, incoming_packet_header}, {240'h0, exp_hdr});
      end
   endtask

   task automatic release_hold();
      repeat (2) tick();
      check("kv_hold_stable", {255'h0, key_valid}, 256'd1);
      check("key_hold_stable", key_out, last_key);
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      check("kv_after_ack", {255'h0, key_valid}, 256'd0);
      check("wc_after_ack", {251'h0, word_count}, 256'd0);
      check("key_after_ack", key_out, last_key);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_key"}, key_out, '0);
      check({tag, "_hdr"}, {240'h0, incoming_packet_header}, '0);
      check({tag, "_misc"}, {248'h0, key_valid, word_count, rx_error, dropped}, '0);
   endtask

   vec_t vecs[4];

   initial begin
      vecs[0] = '{hdr: 16'h2ABC, base: 16'h5555, incr: 1'b0, gap: 0, accept: 1'b0};
      vecs[1] = '{hdr: 16'h1234, base: 16'h5555, incr: 1'b0, gap: 0, accept: 1'b1};
      vecs[2] = '{hdr: 16'h1000, base: 16'h0001, incr: 1'b1, gap: 3, accept: 1'b1};
      vecs[3] = '{hdr: 16'h1ABC, base: 16'hF00D, incr: 1'b1, gap: 1, accept: 1'b1};

      reset_n  = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 16'h0;
      key_ack  = 1'b0;
      repeat (2) tick();
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();

      for (int v = 0; v < 4; v++) begin
         send_packet(vecs[v].hdr, vecs[v].base, vecs[v].incr, vecs[v].gap, vecs[v].accept);
         if (vecs[v].accept) release_hold();
      end

      // Payload timeout after five words.
      err_cnt = 0;
      exp_hdr = 16'h1001;
      send(16'h1001);
      for (int i = 0; i < 5; i++) send(16'h0100 + 16'(i));
      check("wc_5", {251'h0, word_count}, 256'd5);
      repeat (TMO - 1) tick();
      check("err_early", {255'h0, rx_error}, 256'd0);
      tick();
      check("err_pulse", {255'h0, rx_error}, 256'd1);
      check("wc_tmo", {251'h0, word_count}, 256'd0);
      check("kv_tmo", {255'h0, key_valid}, 256'd0);
      check("hdr_tmo", {240'h0, incoming_packet_header}, {240'h0, exp_hdr});
      check("key_tmo", key_out, last_key);
      tick();
      check("err_end", {255'h0, rx_error}, 256'd0);
      check("err_count", 256'(err_cnt), 256'd1);

      // HOLD: lone word dropped, then word together with ack, then a new packet is taken.
      send_packet(16'h1111, 16'h2222, 1'b1, 0, 1'b1);
      tick();
      send(16'h1777);
      check("drop_lone", {255'h0, dropped}, 256'd1);
      check("kv_after_drop", {255'h0, key_valid}, 256'd1);
      check("hdr_after_drop", {240'h0, incoming_packet_header}, {240'h0, exp_hdr});
      tick();
      check("drop_clear", {255'h0, dropped}, 256'd0);
      rx_valid = 1'b1;
      rx_data  = 16'h1003;
      key_ack  = 1'b1;
      tick();
      rx_valid = 1'b0;
      key_ack  = 1'b0;
      check("drop_ack", {255'h0, dropped}, 256'd1);
      check("kv_ack_drop", {255'h0, key_valid}, 256'd0);
      check("hdr_ack_drop", {240'h0, incoming_packet_header}, {240'h0, exp_hdr});
      tick();
      check("drop_ack_clear", {255'h0, dropped}, 256'd0);
      // key_ack held high outside HOLD must be ignored; header-typed payload is data.
      key_ack = 1'b1;
      send_packet(16'h1002, 16'h1000, 1'b1, 0, 1'b1);
      key_ack = 1'b0;
      release_hold();

      // Reset in the middle of a payload.
      err_cnt = 0;
      send(16'h1005);
      for (int i = 0; i < 8; i++) send(16'h0A00 + 16'(i));
      reset_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      tick();
      reset_n  = 1'b1;
      exp_hdr  = 16'h0;
      last_key = '0;
      check_all_zero("post_rst");
      send_packet(16'h1234, 16'hA000, 1'b1, 0, 1'b1);
      release_hold();
      check("err_rst", 256'(err_cnt), 256'd0);

      repeat (2) tick();
      check("sb_drain", 256'(sb.size()), 256'd0);
      check("sb_pops", 256'(pops), 256'(pushes));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_packet_receiver.md
KEY_PACKET_RECEIVER -- requirements
Module: key_packet_receiver

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: the maximum idle cycles allowed between payload words.
REQ-002 The block SHALL have parameter KEY_TYPE, default 4'h1: header bits [15:12] value that identifies a key packet.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port rx_valid, input, 1 bit: rx_data holds a link word this cycle.
REQ-006 The block SHALL have port rx_data, input, 16 bits: link word.
REQ-007 The block SHALL have port key_ack, input, 1 bit: the consumer has taken key_out.
REQ-008 The block SHALL have port incoming_packet_header, output, 16 bits: header of the last accepted key packet.
REQ-009 The block SHALL have port key_out, output, 256 bits: assembled key; this is the curve-engine operand that feeds the sending stage.
REQ-010 The block SHALL have port key_valid, output, 1 bit: key_out is complete and stable.
REQ-011 The block SHALL have port word_count, output, 5 bits: payload words received in the current packet (0..16).
REQ-012 The block SHALL have port rx_error, output, 1 bit: one-cycle pulse on payload timeout.
REQ-013 The block SHALL have port dropped, output, 1 bit: one-cycle pulse when a word is discarded in HOLD.

Function
REQ-014 The block SHALL implement the states IDLE, PAYLOAD and HOLD.
REQ-015 IDLE: when rx_valid=1 and rx_data[15:12]==KEY_TYPE, the block SHALL latch rx_data into incoming_packet_header, clear word_count and the timeout counter, and enter PAYLOAD.
REQ-016 IDLE: when rx_valid=1 and the type mismatches, the block SHALL ignore the word, stay in IDLE, and raise no error.
REQ-017 PAYLOAD: each rx_valid word SHALL shift into the assembly register as {sr[239:0], rx_data}, so the first payload word ends up in bits [255:240], and SHALL increment word_count.
REQ-018 On the cycle that accepts the 16th payload word, the next edge SHALL load key_out from the assembled value, set key_valid=1, and enter HOLD; key_valid SHALL assert exactly 1 cycle after the 16th word is sampled.
REQ-019 PAYLOAD: the timeout counter SHALL clear on every accepted word and increment on every cycle with rx_valid=0.
REQ-020 When the timeout counter reaches TIMEOUT_CYCLES, the block SHALL pulse rx_error for 1 cycle and return to IDLE; key_out, key_valid and incoming_packet_header SHALL remain unchanged, and word_count SHALL return to 0.
REQ-021 HOLD: key_out and key_valid SHALL stay stable until key_ack=1 is sampled; key_valid SHALL then deassert on the next edge, and the block SHALL enter IDLE with word_count=0.
REQ-022 HOLD: any rx_valid word, including one arriving in the same cycle as key_ack, SHALL be discarded with a dropped pulse; it SHALL NOT start a new packet.
REQ-023 key_ack SHALL be ignored outside HOLD.
REQ-024 A header-typed word arriving in PAYLOAD SHALL be treated as payload data; there SHALL be no resynchronisation.
REQ-025 The timeout counter SHALL be at least clog2(TIMEOUT_CYCLES+1) bits wide and SHALL NOT wrap.

Reset
REQ-026 While reset_n=0, asynchronously and regardless of clock: state=IDLE; key_out=0; incoming_packet_header=0; key_valid=0; word_count=0; rx_error=0; dropped=0; the assembly register and timeout counter SHALL be 0.
REQ-027 Reset asserted mid-PAYLOAD or mid-HOLD SHALL abandon the packet with no rx_error or dropped pulse.
REQ-028 The first edge after reset_n rises SHALL behave as IDLE.

Verification
REQ-029 Header 16'h1234, then 16 back-to-back words 16'h5555 -> key_valid=1 one cycle after the 16th word; key_out is 256'h5555 repeated; incoming_packet_header=16'h1234.
REQ-030 Header 16'h1000, then words 16'h0001..16'h0010 with 3-cycle gaps -> key_out[255:240]=16'h0001, key_out[15:0]=16'h0010, word_count=16 before HOLD.
REQ-031 Header 16'h2ABC (wrong type), then 16 words -> block stays IDLE, key_valid=0, incoming_packet_header=0.
REQ-032 Header 16'h1001, 5 words, then silence for TIMEOUT_CYCLES -> single rx_error pulse, return to IDLE, key_valid=0, word_count=0.
REQ-033 In HOLD, drive rx_valid and key_ack together -> one dropped pulse, key_valid=0 next cycle, and a following header 16'h1002 is accepted.
REQ-034 reset_n pulsed low after 8 payload words -> all outputs 0 immediately; a subsequent full packet assembles correctly.
